// File: rtl/cregs_wbus_arbiter.sv
// Round-robin arbiter and write sequencer for the shared write bus into the
// A/L/Q/Z central registers: one registered grant, one write enable per cycle.
module cregs_wbus_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         req_sel,
  input  logic [WIDTH*NREQ-1:0]     req_data,
  input  logic                      hold,
  output logic [NREQ-1:0]           gnt,
  output logic                      wr_a,
  output logic                      wr_l,
  output logic                      wr_q,
  output logic                      wr_z,
  output logic [WIDTH-1:0]          wbus,
  output logic [$clog2(NREQ)-1:0]   dbg_ptr
);

  localparam int PW = $clog2(NREQ);

  // Handshake: a requester keeps req/req_sel/req_data stable until it sees its
  // gnt bit high; the last mask stops one request from being granted twice.

  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  last;
  logic [NREQ-1:0]  elig;
  logic             win_valid;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;
  logic [1:0]       win_sel;
  logic [WIDTH-1:0] win_data;
  logic [NREQ-1:0]  win_onehot;
  int               idx;

  // Scan from the highest offset down so the last hit is the first index
  // at or after ptr in wrap-around order.
  always_comb begin
    elig      = hold ? '0 : (req & ~last);
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_sel    = req_sel[2*win_idx +: 2];
    win_data   = req_data[WIDTH*win_idx +: WIDTH];
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
    next_ptr   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt  <= '0;
      wr_a <= 1'b0;
      wr_l <= 1'b0;
      wr_q <= 1'b0;
      wr_z <= 1'b0;
      wbus <= '0;
      ptr  <= '0;
      last <= '0;
    end else if (win_valid) begin
      gnt  <= win_onehot;
      wr_a <= (win_sel == 2'd0);
      wr_l <= (win_sel == 2'd1);
      wr_q <= (win_sel == 2'd2);
      wr_z <= (win_sel == 2'd3);
      wbus <= win_data;
      ptr  <= next_ptr;
      last <= win_onehot;
    end else begin
      // No winner: bus keeps its last word, pointer stays put.
      gnt  <= '0;
      wr_a <= 1'b0;
      wr_l <= 1'b0;
      wr_q <= 1'b0;
      wr_z <= 1'b0;
      last <= '0;
    end
  end

  assign dbg_ptr = ptr;

endmodule
